// File: rtl/bmc_decoder.sv
// Biphase-mark receive decoder: synchronises the CC line, times the gaps between
// transitions and turns half/full unit intervals into NRZ bit strobes.
module bmc_decoder #(
  parameter int system_khz = 200000,
  parameter int bit_khz    = 300
) (
  input  logic clock,
  input  logic nrst,
  input  logic enable,
  input  logic bmc_d,
  output logic data,
  output logic valid,
  output logic active,
  output logic err
);

  localparam int UI   = system_khz / bit_khz;
  localparam int HMIN = UI / 4;
  localparam int THR  = UI * 3 / 4;
  localparam int FMAX = UI * 5 / 4;
  localparam int TOUT = UI * 2;
  localparam int CW   = $clog2(TOUT + 1);

  localparam logic [CW-1:0] HMIN_C = CW'(HMIN);
  localparam logic [CW-1:0] THR_C  = CW'(THR);
  localparam logic [CW-1:0] FMAX_C = CW'(FMAX);
  localparam logic [CW-1:0] TOUT_C = CW'(TOUT);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          half_pend, half_nxt;
  logic          valid_nxt, err_nxt, data_nxt;
  logic          sync1, sync2, sync3, edge_q;

  // Two-flop synchroniser, then a registered transition detect.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      sync1  <= bmc_d;
      sync2  <= sync1;
      sync3  <= sync2;
      edge_q <= sync2 ^ sync3;
    end
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cnt       <= '0;
      half_pend <= 1'b0;
      valid     <= 1'b0;
      err       <= 1'b0;
      data      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      half_pend <= half_nxt;
      valid     <= valid_nxt;
      err       <= err_nxt;
      data      <= data_nxt;
    end
  end

  // The interval just measured is the count value before an edge reloads it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == TOUT_C) ? cnt : cnt + ONE_C;
    half_nxt  = half_pend;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    data_nxt  = data;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      half_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          half_nxt = 1'b0;
          if (edge_q) begin
            state_nxt = RUN;
            cnt_nxt   = ONE_C;
          end
        end
        RUN: begin
          if (cnt == TOUT_C) begin
            // Timeout beats a coincident edge; a dangling half bit is an error.
            state_nxt = IDLE;
            half_nxt  = 1'b0;
            err_nxt   = half_pend;
          end else if (edge_q) begin
            cnt_nxt = ONE_C;
            if (cnt < HMIN_C) begin
              err_nxt  = 1'b1;
              half_nxt = 1'b0;
            end else if (cnt < THR_C) begin
              if (half_pend) begin
                valid_nxt = 1'b1;
                data_nxt  = 1'b1;
                half_nxt  = 1'b0;
              end else begin
                half_nxt = 1'b1;
              end
            end else if (cnt <= FMAX_C) begin
              if (half_pend) begin
                err_nxt  = 1'b1;
                half_nxt = 1'b0;
              end else begin
                valid_nxt = 1'b1;
                data_nxt  = 1'b0;
              end
            end else begin
              err_nxt  = 1'b1;
              half_nxt = 1'b0;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign active = (state == RUN);

endmodule

// File: tb/tb_bmc_decoder.sv
// Randomised and directed bench for bmc_decoder; expected strobes come from an
// interval-level model of the BMC rules, timed from the cycle each line edge is driven.
module tb_bmc_decoder;

  localparam int UI   = 200000 / 300;
  localparam int HMIN = UI / 4;
  localparam int THR  = UI * 3 / 4;
  localparam int FMAX = UI * 5 / 4;
  localparam int TOUT = UI * 2;
  localparam int LAT  = 4;

  logic clock = 1'b0;
  logic nrst = 1'b0;
  logic enable = 1'b0;
  logic bmc_d = 1'b0;
  logic data, valid, active, err;

  int cyc = 0;
  int nChecks = 0;
  int nPass = 0;
  int overlaps = 0;
  logic actPrev = 1'b0;

  int ivl[$];
  int edgeCyc[$];
  int expValCyc[$], expValData[$], expErrCyc[$], expActCyc[$], expActVal[$];
  int actValCyc[$], actValData[$], actErrCyc[$], actActCyc[$], actActVal[$];

  bmc_decoder #(.system_khz(200000), .bit_khz(300)) dut (
    .clock (clock),
    .nrst  (nrst),
    .enable(enable),
    .bmc_d (bmc_d),
    .data  (data),
    .valid (valid),
    .active(active),
    .err   (err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Event recorder: every strobe and every change of carrier-present, stamped by cycle.
  always @(negedge clock) begin
    if (valid) begin
      actValCyc.push_back(cyc);
      actValData.push_back(int'(data));
    end
    if (err) actErrCyc.push_back(cyc);
    if (valid && err) overlaps++;
    if (active !== actPrev) begin
      actActCyc.push_back(cyc);
      actActVal.push_back(int'(active));
    end
    actPrev = active;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nChecks++;
    if (observed == expected) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic clearAll();
    expValCyc.delete(); expValData.delete(); expErrCyc.delete();
    expActCyc.delete(); expActVal.delete();
    actValCyc.delete(); actValData.delete(); actErrCyc.delete();
    actActCyc.delete(); actActVal.delete();
  endtask

  task automatic compareQueues(input string tag);
    int n;
    checkOutput({tag, " valid_count"}, actValCyc.size(), expValCyc.size());
    n = (actValCyc.size() < expValCyc.size()) ? actValCyc.size() : expValCyc.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, " valid_cycle"}, actValCyc[i], expValCyc[i]);
      checkOutput({tag, " valid_data"}, actValData[i], expValData[i]);
    end
    checkOutput({tag, " err_count"}, actErrCyc.size(), expErrCyc.size());
    n = (actErrCyc.size() < expErrCyc.size()) ? actErrCyc.size() : expErrCyc.size();
    for (int i = 0; i < n; i++)
      checkOutput({tag, " err_cycle"}, actErrCyc[i], expErrCyc[i]);
    checkOutput({tag, " active_count"}, actActCyc.size(), expActCyc.size());
    n = (actActCyc.size() < expActCyc.size()) ? actActCyc.size() : expActCyc.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, " active_cycle"}, actActCyc[i], expActCyc[i]);
      checkOutput({tag, " active_value"}, actActVal[i], expActVal[i]);
    end
    clearAll();
  endtask

  // Expected events for one burst that starts from idle: edge 0 is the lead-in.
  task automatic modelSegment(input bit withTimeout);
    bit pend = 1'b0;
    int d, s, tEnd;
    expActCyc.push_back(edgeCyc[0] + LAT);
    expActVal.push_back(1);
    for (int i = 1; i < edgeCyc.size(); i++) begin
      d = edgeCyc[i] - edgeCyc[i-1];
      s = edgeCyc[i] + LAT;
      if (d < HMIN) begin
        expErrCyc.push_back(s);
        pend = 1'b0;
      end else if (d < THR) begin
        if (pend) begin
          expValCyc.push_back(s);
          expValData.push_back(1);
          pend = 1'b0;
        end else pend = 1'b1;
      end else if (d <= FMAX) begin
        if (pend) begin
          expErrCyc.push_back(s);
          pend = 1'b0;
        end else begin
          expValCyc.push_back(s);
          expValData.push_back(0);
        end
      end else begin
        expErrCyc.push_back(s);
        pend = 1'b0;
      end
    end
    if (withTimeout) begin
      tEnd = edgeCyc[edgeCyc.size()-1] + LAT + TOUT;
      if (pend) expErrCyc.push_back(tEnd);
      expActCyc.push_back(tEnd);
      expActVal.push_back(0);
    end
  endtask

  task automatic loadBits(input int half, input int full, input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (bits[i]) begin
        ivl.push_back(half);
        ivl.push_back(half);
      end else ivl.push_back(full);
    end
  endtask

  task automatic driveSegment();
    edgeCyc.delete();
    @(negedge clock);
    bmc_d = ~bmc_d;
    edgeCyc.push_back(cyc);
    foreach (ivl[i]) begin
      repeat (ivl[i]) @(negedge clock);
      bmc_d = ~bmc_d;
      edgeCyc.push_back(cyc);
    end
    ivl.delete();
  endtask

  task automatic applyStimulus(input string tag);
    driveSegment();
    modelSegment(1'b1);
    repeat (TOUT + 20) @(negedge clock);
    compareQueues(tag);
  endtask

  initial begin
    int c, rate, ui, j;
    logic [15:0] rbits;

    // Reset held while the line toggles.
    for (int i = 0; i < 10; i++) begin
      repeat (2) @(negedge clock);
      bmc_d = ~bmc_d;
      if (i % 3 == 0) checkOutput("reset outputs", int'({data, valid, active, err}), 0);
    end
    @(negedge clock);
    nrst = 1'b1;
    enable = 1'b1;
    repeat (100) @(negedge clock);
    checkOutput("reset active_static", int'(active), 0);
    compareQueues("reset");

    loadBits(333, 667, 16'b10011010, 8);
    applyStimulus("nominal_300k");
    loadBits(370, 741, 16'b10011010, 8);
    applyStimulus("rate_270k");
    loadBits(303, 606, 16'b10011010, 8);
    applyStimulus("rate_330k");

    for (int k = 0; k < 3; k++) begin
      rate = int'($urandom_range(330, 270));
      ui = 200000 / rate;
      rbits = 16'($urandom);
      for (int i = 0; i < 5; i++) begin
        j = int'($urandom_range(8)) - 4;
        if (rbits[i]) begin
          ivl.push_back(ui / 2 + j);
          ivl.push_back(ui / 2 - j);
        end else ivl.push_back(ui + j);
      end
      applyStimulus("random_rate");
    end

    ivl = '{667, 323, 20, 324, 667, 333, 333, 667};
    applyStimulus("glitch");
    ivl = '{667, 333, 667, 333, 333, 667, 333, 333};
    applyStimulus("half_then_full");
    ivl = '{667, HMIN - 1, 667, HMIN, THR - 1, THR, FMAX, FMAX + 1, 667, 333};
    applyStimulus("boundaries");

    // Enable dropped mid-packet: nothing more may be decoded until a new lead-in.
    loadBits(333, 667, 16'b1011, 4);
    driveSegment();
    modelSegment(1'b0);
    repeat (100) @(negedge clock);
    enable = 1'b0;
    c = cyc;
    expActCyc.push_back(c + 1);
    expActVal.push_back(0);
    repeat (4) begin
      repeat (333) @(negedge clock);
      bmc_d = ~bmc_d;
    end
    repeat (100) @(negedge clock);
    enable = 1'b1;
    repeat (20) @(negedge clock);
    compareQueues("enable_drop");
    loadBits(333, 667, 16'b01101001, 8);
    applyStimulus("reenable");

    // Asynchronous reset in the middle of a packet.
    loadBits(333, 667, 16'b01, 2);
    driveSegment();
    repeat (100) @(negedge clock);
    checkOutput("pre_reset active", int'(active), 1);
    checkOutput("pre_reset data", int'(data), 1);
    nrst = 1'b0;
    #1;
    checkOutput("async_reset outputs", int'({data, valid, active, err}), 0);
    bmc_d = 1'b0;
    repeat (10) @(negedge clock);
    nrst = 1'b1;
    repeat (20) @(negedge clock);
    clearAll();
    checkOutput("post_reset idle", int'(active), 0);
    loadBits(333, 667, 16'b1100, 4);
    applyStimulus("post_reset");

    checkOutput("valid_err_overlap", overlaps, 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/bmc_decoder.md
# bmc_decoder

Biphase-mark (BMC) receive decoder for the USB-PD CC line; the receive-side counterpart of `bmc_encoder`. It synchronises the raw CC comparator output, measures the interval between line transitions and classifies each interval as a half or full unit interval (UI). From those intervals it recovers NRZ bits as single-cycle `valid` strobes. It sits between the CC analog front end and the 4b5b/packet receive logic, and tolerates the PD bit-rate window of 270–330 kbps.

## Interface
- `system_khz`, 200000, clock frequency in kHz.
- `bit_khz`, 300, nominal bit rate in kHz.
- `clock`  in  1  system clock; all logic on rising edge.
- `nrst`  in  1  asynchronous active-low reset.
- `enable`  in  1  decoder enable; low forces IDLE synchronously.
- `bmc_d`  in  1  raw BMC line (asynchronous to `clock`).
- `data`  out  1  decoded bit; meaningful only when `valid`=1.
- `valid`  out  1  one-cycle strobe, one per decoded bit.
- `active`  out  1  carrier present (edges inside timeout).
- `err`  out  1  one-cycle strobe on a malformed interval.

## Operation
- Derived constants (integer math):
  - UI = system_khz/bit_khz
  - HMIN = UI/4
  - THR = UI*3/4
  - FMAX = UI*5/4
  - TOUT = UI*2
- Defaults: 666 / 166 / 499 / 832 / 1332.
- Interval counter width is clog2(TOUT+1); the counter saturates at TOUT.
- `bmc_d` passes through a 2-FF synchroniser. `edge` = sync output XOR its registered copy.
- Counter `cnt`: loads 1 on an `edge` cycle, otherwise increments. On an edge, the measured interval is `cnt` before the load.
- State IDLE:
  - `active`=0 and `half_pend`=0.
  - On the first `edge`: go to RUN, load `cnt`, emit nothing. This is the preamble lead-in edge.
- State RUN, `active`=1. On `edge`, classify the interval I:
  - I < HMIN: glitch. Pulse `err`, clear `half_pend`, emit nothing.
  - HMIN ≤ I < THR: half. If `half_pend`=0, set it. If `half_pend`=1, emit `data`=1 and clear it.
  - THR ≤ I ≤ FMAX: full. If `half_pend`=0, emit `data`=0. If `half_pend`=1, pulse `err`, clear `half_pend`, emit nothing.
  - I > FMAX (and `cnt` < TOUT): pulse `err`, clear `half_pend`, emit nothing.
- In RUN, when `cnt` reaches TOUT with no edge:
  - Go to IDLE and drop `active`.
  - If `half_pend`=1, pulse `err` in the same cycle.
- `enable`=0 returns to IDLE, clears `cnt` and `half_pend`, and holds `valid` and `err` at 0. The synchroniser keeps running.
- `data` holds its last value between strobes.

## Timing
- Reset (`nrst`=0): all outputs 0, state IDLE, `cnt`=0, `half_pend`=0, synchroniser flops 0.
- Latency: `valid`/`data`/`err` assert on the 4th rising `clock` edge after the `bmc_d` transition that completes the interval (2 sync + 1 edge + 1 decode register).
- `active` rises with the same 4-cycle latency after the first edge. It falls on the cycle `cnt` hits TOUT.
- `valid` and `err` are never high in the same cycle. Each is high for exactly one cycle.
- Simultaneous `edge` and `cnt`=TOUT: the timeout wins and the edge is ignored. The next edge restarts from IDLE as a new lead-in.
- `enable` falling mid-bit: no partial bit is emitted. `enable` rising: the decoder starts in IDLE and waits for a lead-in edge.
- `nrst` asserted mid-packet: outputs clear immediately (asynchronous). Decoding resumes from IDLE after release.

## Test plan
- **Reset.** Drive `nrst`=0 for 100 ns with `bmc_d` toggling → `valid`, `err`, `active`, `data` all stay 0. After release with `bmc_d` static → `active` remains 0.
- **Nominal decode.** At 200 MHz, 300 kbps: send a lead-in edge, then BMC bits 1,0,0,1,1,0,1,0 (half = 333 cycles, full = 667 cycles) → exactly 8 `valid` pulses, `data` sequence 1,0,0,1,1,0,1,0, `err` never asserts.
- **Rate tolerance.** Repeat the nominal decode at 270 kbps (UI 741 cycles) and at 330 kbps (UI 606 cycles) → identical 8-bit output, no `err`.
- **Glitch and malformed intervals.** Inject a 20-cycle pulse in the middle of a 0 bit → one `err` pulse. Send a half interval followed by a full interval → `err`. After the next well-formed bit → decoding resumes with correct `data`.
- **Idle timeout.** Stop toggling after the last bit → `active` falls exactly 1332 cycles after the last detected edge. If stopped after an odd half interval → an `err` pulse coincides with `active` falling.
- **Enable/reset mid-packet and loopback.** Drop `enable` after bit 4 → no further `valid`. Re-enable with a new lead-in → decodes correctly. Loop `bmc_encoder` `dmc_q` into `bmc_d` → the received bits equal the transmitted `data`.
